fetch_predictor: RTL and testbench
==================================

# fetch_predictor

Instruction-fetch stage with a 2-bit bimodal branch history table (BHT). It owns the PC and addresses instruction memory. It predecodes the fetched word so predicted-taken branches and jumps redirect with zero bubbles, and it supplies the instruction and BHT state snapshot that the IF/ID stage register captures. It also accepts branch resolutions from EX to train the BHT and to recover from mispredictions.

## Interface
- `BHT_BITS`, default 6: log2 of BHT entries; index = `pc[BHT_BITS+1:2]`.
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.
- `clk` in 1: the single clock. All state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `stall` in 1: hold the PC this cycle. The same hazard signal drives the IF/ID enable low.
- `imem_addr` out 32: current PC, equal to the `pc` register.
- `imem_data` in 32: instruction at `imem_addr`, valid in the same cycle (combinational memory).
- `inst_out` out 32: equal to `imem_data`, goes to IF/ID.
- `pc_out` out 32: equal to the PC, goes to IF/ID.
- `bht_state_out` out 2: BHT entry read at the PC index, goes to IF/ID and travels down the pipeline.
- `pred_taken` out 1: this cycle's fetch was redirected by prediction.
- `upd_valid` in 1: EX resolved a conditional branch (beq/bne only).
- `upd_pc` in 32: PC of the resolved branch.
- `upd_taken` in 1: actual branch outcome.
- `upd_bht_state` in 2: the snapshot that travelled with the branch.
- `upd_mispredict` in 1: EX detected a wrong next-PC.
- `upd_redirect_pc` in 32: correct next PC when `upd_mispredict` is high.
- `ifid_clear_n` out 1: active-low, drives the IF/ID clear input. Equals `!upd_mispredict`.

## Operation
- Predecode on `imem_data[31:26]`:
  - `6'h02` (j) and `6'h03` (jal): always taken. Target = `{pc+4[31:28], imem_data[25:0], 2'b00}`.
  - `6'h04` (beq) and `6'h05` (bne): taken iff `bht_state_out[1]`. Target = `pc + 4 + (sext(imm16) << 2)`.
  - All other opcodes: never taken.
- `pred_taken` = jump, or (branch and `bht_state_out[1]`). It is 0 whenever `stall` or `upd_mispredict` is high.
- Next-PC priority:
  1. `rst`: `RESET_PC`.
  2. `upd_mispredict`: `upd_redirect_pc`. This overrides `stall`.
  3. `stall`: hold the PC.
  4. `pred_taken`: predicted target.
  5. Otherwise `pc + 4`.
- All PC arithmetic is 32-bit modulo. `pc + 4` at `32'hFFFF_FFFC` wraps to 0.
- BHT state encoding: 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, 11 strongly-taken. Reset value of every entry is 01.
- BHT update:
  - Happens when `upd_valid` is high, at entry `upd_pc[BHT_BITS+1:2]`.
  - New value is `upd_bht_state` plus 1 if `upd_taken`, minus 1 otherwise, saturating at 11 and 00.
  - The update is computed from the carried snapshot, not a re-read. Later updates to the same entry overwrite earlier ones.
  - The update is independent of `stall` and `upd_mispredict`.
- Same-cycle read and write to one index: the read returns the old value (no bypass). The new value is visible from the next cycle.
- Different PCs with equal index bits share one entry (aliasing, no tags).

## Timing
- Reset, asynchronous and taking effect immediately on `rst` rising:
  - `pc` = `RESET_PC`, all BHT entries = 01.
  - `imem_addr` and `pc_out` = `RESET_PC`; `bht_state_out` = 01.
  - `inst_out` follows `imem_data`.
  - `pred_taken` is 0 unless `imem_data` decodes as a jump, or as a branch with `bht_state_out[1]` (unreachable while all entries are 01).
  - `ifid_clear_n` = `!upd_mispredict` (1 when `upd_mispredict` is low).
- Reset mid-operation discards all training.
- PC latency: the next-PC selection is registered at the following rising edge.
- Predicted-taken jumps and branches: the target is fetched in the next cycle, zero bubbles.
- Mispredict:
  - `ifid_clear_n` falls combinationally in the same cycle as `upd_mispredict`, so the wrong-path instruction entering IF/ID is zeroed at that edge.
  - `upd_redirect_pc` is fetched in the next cycle.
- `upd_valid` and `upd_mispredict` are single-cycle pulses per resolved branch and may coincide.

## Structure
- `Core.vh` gets these shared constants:
  - Opcodes `OP_J`, `OP_JAL`, `OP_BEQ`, `OP_BNE`.
  - BHT encodings `BHT_SNT`, `BHT_WNT`, `BHT_WT`, `BHT_ST`.
  - BHT reset state `BHT_INIT = BHT_WNT`.
- Sub-module `bht_table`:
  - 2^`BHT_BITS` x 2 flop array with async reset.
  - One combinational read port; one write port with the saturating-update logic.
- The top level holds the PC register, predecode, target adders and next-PC mux.

## Test plan
- Reset sequencing: hold `rst`, release, feed nops. `imem_addr` = 0, 4, 8 on consecutive cycles; `bht_state_out` = 01; `ifid_clear_n` = 1.
- Jump: at PC 0x10, `imem_data` = `j` with index 0x40. Next `imem_addr` = 0x100 with no bubble; `pred_taken` = 1 for exactly one cycle.
- Branch training:
  - beq at 0x20 with imm 3 and entry 01: fall through to 0x24.
  - Apply two updates (taken/01, then taken/10). The entry becomes 11.
  - Refetch 0x20: next PC 0x30, `bht_state_out` = 11.
- Saturation and aliasing with `BHT_BITS` = 6:
  - Update taken with snapshot 11: entry stays 11.
  - Update not-taken with snapshot 00: entry stays 00.
  - Train 0x000 to 11: a branch at 0x100 reads 11.
- Stall vs mispredict: `stall` = 1 and `upd_mispredict` = 1 with redirect 0x200 in the same cycle. `ifid_clear_n` = 0 that cycle; the next `imem_addr` = 0x200.
- Async reset mid-run: assert `rst` between edges while the PC is 0x44 and an entry is 11. The PC is immediately `RESET_PC` and all entries read 01.

Source files
------------

// File: rtl/fetch_predictor_pkg.sv
// rtl/fetch_predictor_pkg.sv - shared opcodes, BHT encodings and saturating counter helper
package fetch_predictor_pkg;

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    localparam logic [1:0] BHT_SNT  = 2'b00;
    localparam logic [1:0] BHT_WNT  = 2'b01;
    localparam logic [1:0] BHT_WT   = 2'b10;
    localparam logic [1:0] BHT_ST   = 2'b11;
    localparam logic [1:0] BHT_INIT = BHT_WNT;

    // Two-bit saturating counter step from the snapshot carried down the pipe.
    function automatic logic [1:0] bht_next(input logic [1:0] state, input logic taken);
        logic [1:0] result;
        result = state;
        if (taken && state != BHT_ST) begin
            result = state + 2'd1;
        end else if (!taken && state != BHT_SNT) begin
            result = state - 2'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fetch_predictor_if.sv
// rtl/fetch_predictor_if.sv - instruction memory port and EX branch-resolution bus
interface fetch_predictor_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [1:0]  upd_bht_state;
    logic        upd_mispredict;
    logic [31:0] upd_redirect_pc;

    modport master (
        output imem_addr,
        input  imem_data,
        input  upd_valid,
        input  upd_pc,
        input  upd_taken,
        input  upd_bht_state,
        input  upd_mispredict,
        input  upd_redirect_pc
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output upd_valid,
        output upd_pc,
        output upd_taken,
        output upd_bht_state,
        output upd_mispredict,
        output upd_redirect_pc
    );
endinterface

// File: rtl/fetch_predictor_bht_table.sv
// rtl/fetch_predictor_bht_table.sv - bimodal history table, one async read port, one training write port
module bht_table
    import fetch_predictor_pkg::*;
#(
    parameter int BHT_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BHT_BITS-1:0] rd_idx,
    output logic [1:0]          rd_state,
    input  logic                wr_en,
    input  logic [BHT_BITS-1:0] wr_idx,
    input  logic                wr_taken,
    input  logic [1:0]          wr_state
);
    localparam int ENTRIES = 1 << BHT_BITS;

    logic [1:0] entries [ENTRIES];

    // Read sees the pre-write value on a same-index collision; no bypass.
    assign rd_state = entries[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries[i] <= BHT_INIT;
            end
        end else if (wr_en) begin
            entries[wr_idx] <= bht_next(wr_state, wr_taken);
        end
    end
endmodule

// File: rtl/fetch_predictor.sv
// rtl/fetch_predictor.sv - fetch stage: PC register, predecode, zero-bubble predicted redirect
module fetch_predictor
    import fetch_predictor_pkg::*;
#(
    parameter int          BHT_BITS = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    fetch_predictor_if.master  bus,
    output logic [31:0]        inst_out,
    output logic [31:0]        pc_out,
    output logic [1:0]         bht_state_out,
    output logic               pred_taken,
    output logic               ifid_clear_n
);
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [5:0]  opcode;
    logic        is_jump;
    logic        is_branch;
    logic        unused_upd_pc_bits;

    assign bus.imem_addr = pc;
    assign pc_out        = pc;
    assign inst_out      = bus.imem_data;
    assign ifid_clear_n  = !bus.upd_mispredict;

    assign opcode    = bus.imem_data[31:26];
    assign is_jump   = (opcode == OP_J) || (opcode == OP_JAL);
    assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);

    assign pc_plus4      = pc + 32'd4;
    assign jump_target   = {pc_plus4[31:28], bus.imem_data[25:0], 2'b00};
    assign branch_target = pc_plus4 + {{14{bus.imem_data[15]}}, bus.imem_data[15:0], 2'b00};

    // A stalled or flushed fetch must not claim a redirect.
    assign pred_taken = (is_jump || (is_branch && bht_state_out[1]))
                        && !stall && !bus.upd_mispredict;

    assign unused_upd_pc_bits = ^{bus.upd_pc[31:BHT_BITS+2], bus.upd_pc[1:0]};

    bht_table #(
        .BHT_BITS (BHT_BITS)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pc[BHT_BITS+1:2]),
        .rd_state (bht_state_out),
        .wr_en    (bus.upd_valid),
        .wr_idx   (bus.upd_pc[BHT_BITS+1:2]),
        .wr_taken (bus.upd_taken),
        .wr_state (bus.upd_bht_state)
    );

    always_comb begin
        pc_next = pc_plus4;
        if (bus.upd_mispredict) begin
            pc_next = bus.upd_redirect_pc;
        end else if (stall) begin
            pc_next = pc;
        end else if (pred_taken) begin
            pc_next = is_jump ? jump_target : branch_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end
endmodule

// File: tb/tb_fetch_predictor.sv
// tb/tb_fetch_predictor.sv - vector table, corner sequences and model-driven random run for fetch_predictor
module tb_fetch_predictor;
    import fetch_predictor_pkg::*;

    localparam int          BB  = 6;
    localparam logic [31:0] RPC = 32'h0000_0000;

    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] JMP   = 32'h0800_0040;
    localparam logic [31:0] BEQ3  = 32'h1000_0003;
    localparam logic [31:0] BNEM2 = 32'h1400_FFFE;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [1:0]  bht_state_out;
    logic        pred_taken;
    logic        ifid_clear_n;

    fetch_predictor_if bus ();

    fetch_predictor #(.BHT_BITS(BB), .RESET_PC(RPC)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .bus           (bus),
        .inst_out      (inst_out),
        .pc_out        (pc_out),
        .bht_state_out (bht_state_out),
        .pred_taken    (pred_taken),
        .ifid_clear_n  (ifid_clear_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic        stall;
        logic        uv;
        logic [31:0] upc;
        logic        utk;
        logic [1:0]  ust;
        logic        um;
        logic [31:0] urd;
        logic [31:0] exp_pc;
        logic [1:0]  exp_bht;
        logic        exp_pred;
        logic [31:0] exp_next;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          passed = 0;
    int          total  = 0;
    logic [1:0]  mbht[64];
    logic [31:0] mpc;

    function automatic vec_t mk(input logic [31:0] inst, input logic st, input logic uv,
                                input logic [31:0] upc, input logic utk, input logic [1:0] ust,
                                input logic um, input logic [31:0] urd, input logic [31:0] epc,
                                input logic [1:0] ebht, input logic epred, input logic [31:0] enext);
        vec_t v;
        v.inst = inst; v.stall = st; v.uv = uv; v.upc = upc; v.utk = utk; v.ust = ust;
        v.um = um; v.urd = urd; v.exp_pc = epc; v.exp_bht = ebht; v.exp_pred = epred;
        v.exp_next = enext;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        bus.imem_data       = v.inst;
        stall               = v.stall;
        bus.upd_valid       = v.uv;
        bus.upd_pc          = v.upc;
        bus.upd_taken       = v.utk;
        bus.upd_bht_state   = v.ust;
        bus.upd_mispredict  = v.um;
        bus.upd_redirect_pc = v.urd;
    endtask

    task automatic step(input vec_t v, input string tag);
        logic [31:0] e;
        drive(v);
        @(negedge clk);
        chk({tag, " imem_addr"}, bus.imem_addr, v.exp_pc);
        chk({tag, " pc_out"}, pc_out, v.exp_pc);
        chk({tag, " inst_out"}, inst_out, v.inst);
        chk({tag, " bht_state"}, {30'd0, bht_state_out}, {30'd0, v.exp_bht});
        chk({tag, " pred_taken"}, {31'd0, pred_taken}, {31'd0, v.exp_pred});
        chk({tag, " ifid_clear_n"}, {31'd0, ifid_clear_n}, {31'd0, !v.um});
        exp_q.push_back(v.exp_next);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            $display("FAIL %s scoreboard: queue empty", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " next_pc"}, bus.imem_addr, e);
        end
    endtask

    function automatic logic [1:0] model_sat(input logic [1:0] s, input logic tk);
        if (tk) return (s == 2'b11) ? 2'b11 : s + 2'd1;
        return (s == 2'b00) ? 2'b00 : s - 2'd1;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        chk("reset imem_addr", bus.imem_addr, RPC);
        chk("reset pc_out", pc_out, RPC);
        chk("reset bht_state", {30'd0, bht_state_out}, 32'd1);
        chk("reset ifid_clear_n", {31'd0, ifid_clear_n}, 32'd1);
        chk("reset pred_taken", {31'd0, pred_taken}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // inst, stall, uv, upc, utk, ust, um, urd, exp_pc, exp_bht, exp_pred, exp_next
        vecs.push_back(mk(NOP,   0, 0, 0,     0, 0, 0, 0,     32'h00, 1, 0, 32'h04));
        vecs.push_back(mk(NOP,   0, 0, 0,     0, 0, 0, 0,     32'h04, 1, 0, 32'h08));
        vecs.push_back(mk(NOP,   0, 0, 0,     0, 0, 0, 0,     32'h08, 1, 0, 32'h0C));
        vecs.push_back(mk(NOP,   0, 0, 0,     0, 0, 0, 0,     32'h0C, 1, 0, 32'h10));
        vecs.push_back(mk(JMP,   0, 0, 0,     0, 0, 0, 0,     32'h10, 1, 1, 32'h100));
        vecs.push_back(mk(NOP,   0, 0, 0,     0, 0, 0, 0,     32'h100, 1, 0, 32'h104));
        vecs.push_back(mk(NOP,   0, 0, 0,     0, 0, 1, 32'h20, 32'h104, 1, 0, 32'h20));
        vecs.push_back(mk(BEQ3,  0, 1, 32'h20, 1, 1, 0, 0,    32'h20, 1, 0, 32'h24));
        vecs.push_back(mk(NOP,   0, 1, 32'h20, 1, 2, 0, 0,    32'h24, 1, 0, 32'h28));
        vecs.push_back(mk(NOP,   0, 0, 0,     0, 0, 1, 32'h20, 32'h28, 1, 0, 32'h20));
        vecs.push_back(mk(BEQ3,  0, 0, 0,     0, 0, 0, 0,     32'h20, 3, 1, 32'h30));
        vecs.push_back(mk(NOP,   0, 1, 32'h20, 1, 3, 0, 0,    32'h30, 1, 0, 32'h34));
        vecs.push_back(mk(NOP,   0, 1, 32'h34, 0, 0, 0, 0,    32'h34, 1, 0, 32'h38));
        vecs.push_back(mk(JMP,   1, 0, 0,     0, 0, 1, 32'h34, 32'h38, 1, 0, 32'h34));
        vecs.push_back(mk(NOP,   0, 0, 0,     0, 0, 0, 0,     32'h34, 0, 0, 32'h38));
        vecs.push_back(mk(JMP,   1, 0, 0,     0, 0, 0, 0,     32'h38, 1, 0, 32'h38));
        vecs.push_back(mk(BNEM2, 0, 1, 32'h00, 1, 2, 0, 0,    32'h38, 1, 0, 32'h3C));
        vecs.push_back(mk(NOP,   0, 0, 0,     0, 0, 1, 32'h100, 32'h3C, 1, 0, 32'h100));
        vecs.push_back(mk(BEQ3,  0, 0, 0,     0, 0, 0, 0,     32'h100, 3, 1, 32'h110));
        vecs.push_back(mk(NOP,   0, 1, 32'h38, 1, 2, 0, 0,    32'h110, 1, 0, 32'h114));
        vecs.push_back(mk(NOP,   0, 0, 0,     0, 0, 1, 32'h38, 32'h114, 1, 0, 32'h38));
        vecs.push_back(mk(BNEM2, 0, 0, 0,     0, 0, 0, 0,     32'h38, 3, 1, 32'h34));
        vecs.push_back(mk(NOP,   0, 0, 0,     0, 0, 1, 32'hFFFF_FFFC, 32'h34, 0, 0, 32'hFFFF_FFFC));
        vecs.push_back(mk(NOP,   0, 0, 0,     0, 0, 0, 0,     32'hFFFF_FFFC, 1, 0, 32'h0));
        vecs.push_back(mk(NOP,   0, 0, 0,     0, 0, 0, 0,     32'h00, 3, 0, 32'h04));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("v%0d", i));
        end

        // Asynchronous reset between edges with trained entries present.
        step(mk(NOP, 0, 0, 0, 0, 0, 1, 32'h44, 32'h04, 1, 0, 32'h44), "pre_rst");
        drive(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst imem_addr", bus.imem_addr, RPC);
        chk("async_rst pc_out", pc_out, RPC);
        chk("async_rst bht idx0", {30'd0, bht_state_out}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(mk(NOP,  0, 0, 0, 0, 0, 1, 32'h20, 32'h00, 1, 0, 32'h20), "post_rst0");
        step(mk(BEQ3, 0, 0, 0, 0, 0, 0, 0,      32'h20, 1, 0, 32'h24), "post_rst1");

        // Random run against a behavioural model starting from a cleared table.
        for (int i = 0; i < 64; i++) mbht[i] = 2'b01;
        mpc = 32'h24;
        for (int c = 0; c < 300; c++) begin
            vec_t        v;
            logic [31:0] inst;
            logic [31:0] p4;
            logic [31:0] jt;
            logic [31:0] bt;
            logic [1:0]  b;
            logic        isj;
            logic        isb;
            logic        pr;
            int          kind;
            kind = $urandom_range(0, 4);
            inst = $urandom;
            case (kind)
                0: inst[31:26] = 6'h08;
                1: inst[31:26] = ($urandom_range(0, 1) == 0) ? 6'h02 : 6'h03;
                2: inst[31:26] = 6'h04;
                3: inst[31:26] = 6'h05;
                default: ;
            endcase
            v = mk(inst, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), $urandom,
                   1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 7) == 0), $urandom & 32'hFFFF_FFFC, mpc, 0, 0, 0);
            b   = mbht[mpc[7:2]];
            isj = (inst[31:26] == 6'h02) || (inst[31:26] == 6'h03);
            isb = (inst[31:26] == 6'h04) || (inst[31:26] == 6'h05);
            p4  = mpc + 32'd4;
            jt  = {p4[31:28], inst[25:0], 2'b00};
            bt  = p4 + {{14{inst[15]}}, inst[15:0], 2'b00};
            pr  = (isj || (isb && b[1])) && !v.stall && !v.um;
            v.exp_bht  = b;
            v.exp_pred = pr;
            if (v.um)         v.exp_next = v.urd;
            else if (v.stall) v.exp_next = mpc;
            else if (pr)      v.exp_next = isj ? jt : bt;
            else              v.exp_next = p4;
            step(v, $sformatf("rnd%0d", c));
            if (v.uv) mbht[v.upc[7:2]] = model_sat(v.ust, v.utk);
            mpc = v.exp_next;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
